// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART receive path.
package uart_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_OS         = 8;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_e;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// RX line synchronizer, per-bit oversample counter and 3-sample majority vote.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int OS = DEF_OS
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  rx_in,
    input  logic                  run,
    output logic                  rx_s,
    output logic [$clog2(OS)-1:0] edge_cnt,
    output logic                  bit_vote
);

    localparam int CW = $clog2(OS);
    localparam logic [CW-1:0] CNT_LAST = CW'(OS - 1);
    localparam logic [CW-1:0] SMP_0    = CW'(OS / 2 - 1);
    localparam logic [CW-1:0] SMP_1    = CW'(OS / 2);
    localparam logic [CW-1:0] SMP_2    = CW'(OS / 2 + 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic [CW-1:0] edge_cnt_q, edge_cnt_d;
    logic          s0_q, s0_d;
    logic          s1_q, s1_d;
    logic          s2_q, s2_d;

    always_comb begin
        sync1_d    = rx_in;
        sync2_d    = sync1_q;
        edge_cnt_d = '0;
        if (run) begin
            edge_cnt_d = (edge_cnt_q == CNT_LAST) ? '0 : edge_cnt_q + 1'b1;
        end
        s0_d = (edge_cnt_q == SMP_0) ? sync2_q : s0_q;
        s1_d = (edge_cnt_q == SMP_1) ? sync2_q : s1_q;
        s2_d = (edge_cnt_q == SMP_2) ? sync2_q : s2_q;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            edge_cnt_q <= '0;
            s0_q       <= 1'b1;
            s1_q       <= 1'b1;
            s2_q       <= 1'b1;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            edge_cnt_q <= edge_cnt_d;
            s0_q       <= s0_d;
            s1_q       <= s1_d;
            s2_q       <= s2_d;
        end
    end

    // The vote is usable from the third sample cycle on; in that cycle the
    // third sample is still on the line, so it is taken straight from rx_s.
    assign bit_vote = maj3(s0_q, s1_q, (edge_cnt_q == SMP_2) ? sync2_q : s2_q);
    assign rx_s     = sync2_q;
    assign edge_cnt = edge_cnt_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: frame FSM, shift register and parity/stop checks.
// Parity support is built only when UART_RX_PARITY_EN is defined.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int OS         = DEF_OS
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  Data_valid,
    output logic                  Par_error,
    output logic                  Stop_error,
    output logic                  rx_busy
);

    localparam int CW = $clog2(OS);
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(OS - 1);
    localparam logic [CW-1:0] CNT_EVAL = CW'(OS / 2 + 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

    rx_state_e               state_q, state_d;
    logic                    rx_s;
    logic [CW-1:0]           edge_cnt;
    logic                    bit_vote;
    logic                    run;
    logic [BW-1:0]           bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic                    par_bad_q, par_bad_d;
    logic                    stop_bad_q, stop_bad_d;
    logic                    eval_q, eval_d;
    logic [DATA_WIDTH-1:0]   p_data_q, p_data_d;
    logic                    data_valid_q, data_valid_d;
    logic                    par_error_q, par_error_d;
    logic                    stop_error_q, stop_error_d;

`ifdef UART_RX_PARITY_EN
    logic                    par_en_q, par_en_d;
    logic                    par_typ_q, par_typ_d;
`else
    logic                    unused_par_cfg;
    assign unused_par_cfg = PAR_EN ^ PAR_TYP;
`endif

    assign run = (state_d != IDLE);

    uart_rx_sampler #(
        .OS(OS)
    ) u_sampler (
        .CLK      (CLK),
        .RST      (RST),
        .rx_in    (RX_IN),
        .run      (run),
        .rx_s     (rx_s),
        .edge_cnt (edge_cnt),
        .bit_vote (bit_vote)
    );

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        par_bad_d    = par_bad_q;
        stop_bad_d   = stop_bad_q;
        eval_d       = 1'b0;
        p_data_d     = p_data_q;
        data_valid_d = 1'b0;
        par_error_d  = 1'b0;
        stop_error_d = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_en_d     = par_en_q;
        par_typ_d    = par_typ_q;
`endif

        // Results are published one cycle after the stop-bit decision.
        if (eval_q) begin
            par_error_d  = par_bad_q;
            stop_error_d = stop_bad_q;
            if (!par_bad_q && !stop_bad_q) begin
                p_data_d     = shift_q;
                data_valid_d = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d   = START;
                    bit_cnt_d = '0;
                    par_bad_d = 1'b0;
`ifdef UART_RX_PARITY_EN
                    par_en_d  = PAR_EN;
                    par_typ_d = PAR_TYP;
`endif
                end
            end
            START: begin
                if (edge_cnt == CNT_LAST) begin
                    state_d = bit_vote ? IDLE : DATA;
                end
            end
            DATA: begin
                if (edge_cnt == CNT_LAST) begin
                    shift_d = {bit_vote, shift_q[DATA_WIDTH-1:1]};
                    if (bit_cnt_q == BIT_LAST) begin
                        bit_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
                        state_d   = par_en_q ? PARITY : STOP;
`else
                        state_d   = STOP;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (edge_cnt == CNT_LAST) begin
                    par_bad_d = bit_vote ^ (^shift_q) ^ (par_typ_q == PAR_ODD);
                    state_d   = STOP;
                end
            end
`endif
            STOP: begin
                // Leave early so a start bit right after the stop bit is caught.
                if (edge_cnt == CNT_EVAL) begin
                    stop_bad_d = ~bit_vote;
                    eval_d     = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            par_bad_q    <= 1'b0;
            stop_bad_q   <= 1'b0;
            eval_q       <= 1'b0;
            p_data_q     <= '0;
            data_valid_q <= 1'b0;
            par_error_q  <= 1'b0;
            stop_error_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_en_q     <= 1'b0;
            par_typ_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            par_bad_q    <= par_bad_d;
            stop_bad_q   <= stop_bad_d;
            eval_q       <= eval_d;
            p_data_q     <= p_data_d;
            data_valid_q <= data_valid_d;
            par_error_q  <= par_error_d;
            stop_error_q <= stop_error_d;
`ifdef UART_RX_PARITY_EN
            par_en_q     <= par_en_d;
            par_typ_q    <= par_typ_d;
`endif
        end
    end

    assign P_DATA     = p_data_q;
    assign Data_valid = data_valid_q;
    assign Par_error  = par_error_q;
    assign Stop_error = stop_error_q;
    assign rx_busy    = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frame table, corner sequences and
// randomized frames checked against a frame-level reference model.
module tb_uart_rx;

    localparam int DW = 8;
    localparam int OS = 8;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_BUILD = 1'b1;
`else
    localparam bit PAR_BUILD = 1'b0;
`endif
    localparam int LAT_N = OS * (1 + DW) + OS / 2 + 4;
    localparam int LAT_P = PAR_BUILD ? OS * (2 + DW) + OS / 2 + 4 : LAT_N;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          RX_IN = 1'b1;
    logic          PAR_EN = 1'b0;
    logic          PAR_TYP = 1'b0;
    logic [DW-1:0] P_DATA;
    logic          Data_valid, Par_error, Stop_error, rx_busy;

    uart_rx #(.DATA_WIDTH(DW), .OS(OS)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .RX_IN      (RX_IN),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .P_DATA     (P_DATA),
        .Data_valid (Data_valid),
        .Par_error  (Par_error),
        .Stop_error (Stop_error),
        .rx_busy    (rx_busy)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int            dv_c[$];
    logic [DW-1:0] dv_d[$];
    int            pe_c[$];
    int            se_c[$];

    always @(negedge CLK) begin
        if (!RST) begin
            if (Data_valid) begin
                dv_c.push_back(cyc);
                dv_d.push_back(P_DATA);
            end
            if (Par_error)  pe_c.push_back(cyc);
            if (Stop_error) se_c.push_back(cyc);
        end
    end

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    task automatic clear_q();
        dv_c.delete();
        dv_d.delete();
        pe_c.delete();
        se_c.delete();
    endtask

    // Called just after a negedge; returns the cycle index of the first edge
    // that samples the start bit.
    task automatic send_frame(input logic [DW-1:0] d, input bit with_par, input bit pbit,
                              input bit stop_bit, input bit flip, output int start);
        start = cyc + 1;
        RX_IN = 1'b0;
        repeat (OS) @(negedge CLK);
        for (int i = 0; i < DW; i++) begin
            RX_IN = d[i];
            if (flip && i == 3) begin
                PAR_EN  = ~PAR_EN;
                PAR_TYP = ~PAR_TYP;
            end
            repeat (OS) @(negedge CLK);
        end
        if (with_par) begin
            RX_IN = pbit;
            repeat (OS) @(negedge CLK);
        end
        RX_IN = stop_bit;
        repeat (OS) @(negedge CLK);
        RX_IN = 1'b1;
    endtask

    task automatic check_frame(input string nm, input int start, input int lat, input bit e_dv,
                               input bit e_pe, input bit e_se, input logic [DW-1:0] e_pd);
        check({nm, "/dv_count"}, dv_c.size(), e_dv);
        if (e_dv && dv_c.size() > 0) begin
            check({nm, "/dv_latency"}, dv_c[0] - start, lat);
            check({nm, "/dv_data"}, dv_d[0], e_pd);
        end
        check({nm, "/pe_count"}, pe_c.size(), e_pe);
        if (e_pe && pe_c.size() > 0) check({nm, "/pe_latency"}, pe_c[0] - start, lat);
        check({nm, "/se_count"}, se_c.size(), e_se);
        if (e_se && se_c.size() > 0) check({nm, "/se_latency"}, se_c[0] - start, lat);
        check({nm, "/p_data"}, P_DATA, e_pd);
        clear_q();
    endtask

    typedef struct {
        logic [DW-1:0] data;
        bit            par_en;
        bit            par_typ;
        bit            bad_par;
        bit            stop_bit;
        bit            flip;
        bit            e_dv;
        bit            e_pe;
        bit            e_se;
        logic [DW-1:0] e_pd;
        int            e_lat;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int            s1, s2;
        logic [DW-1:0] model_pd;

        vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5, LAT_N};
        vecs[1] = '{8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h3C, LAT_P};
        vecs[2] = '{8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, !PAR_BUILD, PAR_BUILD, 1'b0, 8'h3C, LAT_P};
        vecs[3] = '{8'h81, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h3C, LAT_N};
        vecs[4] = '{8'h5A, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h5A, LAT_P};
        vecs[5] = '{8'hE7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, PAR_BUILD, 1'b1, 8'h5A, LAT_P};
        vecs[6] = '{8'hC3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'hC3, LAT_N};

        // Reset state
        repeat (4) @(negedge CLK);
        check("reset/p_data", P_DATA, 0);
        check("reset/data_valid", Data_valid, 0);
        check("reset/par_error", Par_error, 0);
        check("reset/stop_error", Stop_error, 0);
        check("reset/rx_busy", rx_busy, 0);
        RST = 1'b0;
        repeat (4) @(negedge CLK);

        // Directed frame table
        for (int i = 0; i < 7; i++) begin
            vec_t v;
            bit   with_par;
            bit   pbit;
            v        = vecs[i];
            PAR_EN   = v.par_en;
            PAR_TYP  = v.par_typ;
            with_par = PAR_BUILD && v.par_en;
            pbit     = (^v.data) ^ v.par_typ ^ v.bad_par;
            send_frame(v.data, with_par, pbit, v.stop_bit, v.flip, s1);
            repeat (16) @(negedge CLK);
            check_frame($sformatf("vec%0d", i), s1, v.e_lat, v.e_dv, v.e_pe, v.e_se, v.e_pd);
        end

        // Back-to-back frames with no idle gap
        PAR_EN  = 1'b0;
        PAR_TYP = 1'b0;
        send_frame(8'h55, 1'b0, 1'b0, 1'b1, 1'b0, s1);
        send_frame(8'hAA, 1'b0, 1'b0, 1'b1, 1'b0, s2);
        repeat (16) @(negedge CLK);
        check("b2b/dv_count", dv_c.size(), 2);
        if (dv_c.size() >= 2) begin
            check("b2b/lat0", dv_c[0] - s1, LAT_N);
            check("b2b/data0", dv_d[0], 8'h55);
            check("b2b/lat1", dv_c[1] - s2, LAT_N);
            check("b2b/data1", dv_d[1], 8'hAA);
            check("b2b/spacing", dv_c[1] - dv_c[0], 10 * OS);
        end
        check("b2b/err_count", pe_c.size() + se_c.size(), 0);
        clear_q();

        // Two-cycle glitch on an idle line
        s1    = cyc + 1;
        RX_IN = 1'b0;
        repeat (2) @(negedge CLK);
        RX_IN = 1'b1;
        repeat (3) @(negedge CLK);
        check("glitch/busy_high", rx_busy, 1);
        repeat (8) @(negedge CLK);
        check("glitch/busy_low", rx_busy, 0);
        repeat (8) @(negedge CLK);
        check("glitch/pulses", dv_c.size() + pe_c.size() + se_c.size(), 0);
        check("glitch/p_data", P_DATA, 8'hAA);
        clear_q();

        // Reset during data bit 4 of 0xF0, then a clean 0x0F
        RX_IN = 1'b0;
        repeat (OS) @(negedge CLK);
        for (int i = 0; i < 4; i++) begin
            RX_IN = (i >= 4);
            repeat (OS) @(negedge CLK);
        end
        RX_IN = 1'b1;
        repeat (OS / 2) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        check("rst_mid/p_data", P_DATA, 0);
        check("rst_mid/data_valid", Data_valid, 0);
        check("rst_mid/par_error", Par_error, 0);
        check("rst_mid/stop_error", Stop_error, 0);
        check("rst_mid/rx_busy", rx_busy, 0);
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        repeat (10) @(negedge CLK);
        send_frame(8'h0F, 1'b0, 1'b0, 1'b1, 1'b0, s1);
        repeat (16) @(negedge CLK);
        check_frame("rst_mid/0F", s1, LAT_N, 1'b1, 1'b0, 1'b0, 8'h0F);

        // Randomized frames against the frame-level model
        model_pd = 8'h0F;
        for (int n = 0; n < 24; n++) begin
            logic [DW-1:0] d;
            bit            pen, ptyp, bad, stop_bit, eff_par, perr, serr, dv;
            int            lat;
            d        = DW'($urandom);
            pen      = 1'($urandom_range(0, 1));
            ptyp     = 1'($urandom_range(0, 1));
            bad      = ($urandom_range(0, 4) == 0);
            stop_bit = ($urandom_range(0, 5) != 0);
            eff_par  = PAR_BUILD && pen;
            lat      = OS * (1 + DW + (eff_par ? 1 : 0)) + OS / 2 + 4;
            perr     = eff_par && bad;
            serr     = !stop_bit;
            dv       = !perr && !serr;
            if (dv) model_pd = d;
            PAR_EN  = pen;
            PAR_TYP = ptyp;
            send_frame(d, eff_par, (^d) ^ ptyp ^ bad, stop_bit, 1'b0, s1);
            repeat (16) @(negedge CLK);
            check_frame($sformatf("rand%0d", n), s1, lat, dv, perr, serr, model_pd);
        end

        // Line stuck low: repeated stop errors, nothing delivered
        PAR_EN = 1'b0;
        s1     = cyc + 1;
        RX_IN  = 1'b0;
        repeat (200) @(negedge CLK);
        check("stuck/se_count", se_c.size(), 2);
        if (se_c.size() > 0) check("stuck/se_first", se_c[0] - s1, LAT_N);
        check("stuck/dv_count", dv_c.size(), 0);
        check("stuck/pe_count", pe_c.size(), 0);
        RST   = 1'b1;
        RX_IN = 1'b1;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        clear_q();
        repeat (4) @(negedge CLK);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
